hazard_ctrl: RTL

Pipeline sequencing controller for the 5-stage MIPS core. It detects load-use and branch-operand hazards and generates the stall, flush and forwarding selects for the F/D/E/M/W pipeline registers. It also sequences data-memory waits through an FSM that has a timeout watchdog, and it keeps a saturating stall-cycle counter. It sits beside the decode-stage control decoder and consumes that decoder's per-stage control bits.

---
 rtl/hazard_ctrl_pkg.sv | 20 ++
 rtl/hazard_ctrl_forward_unit.sv | 37 +++
 rtl/hazard_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the MIPS pipeline hazard controller: memory-wait FSM states,
// forward select codes and the register-compare helper.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  // $0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] i_a, input logic [4:0] i_b);
    return (i_a != 5'd0) && (i_a == i_b);
  endfunction

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// Combinational bypass selects for the E-stage ALU operands and the D-stage
// branch comparator.
module hazard_ctrl_forward_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] i_rs_decode,
  input  logic [4:0] i_rt_decode,
  input  logic [4:0] i_rs_execute,
  input  logic [4:0] i_rt_execute,
  input  logic [4:0] i_writereg_memory,
  input  logic [4:0] i_writereg_writeback,
  input  logic       i_regwrite_memory,
  input  logic       i_regwrite_writeback,
  output logic [1:0] o_forward_decode,
  output logic [1:0] o_forward_a_execute,
  output logic [1:0] o_forward_b_execute
);

  // The M stage holds the younger result, so it wins over W.
  function automatic logic [1:0] fwd_sel(input logic [4:0] i_src,
                                         input logic [4:0] i_wr_m, input logic i_rw_m,
                                         input logic [4:0] i_wr_w, input logic i_rw_w);
    if (i_rw_m && reg_match(i_wr_m, i_src))      return FWD_MEM;
    else if (i_rw_w && reg_match(i_wr_w, i_src)) return FWD_WB;
    else                                         return FWD_NONE;
  endfunction

  always_comb begin
    o_forward_a_execute = fwd_sel(i_rs_execute, i_writereg_memory, i_regwrite_memory,
                                  i_writereg_writeback, i_regwrite_writeback);
    o_forward_b_execute = fwd_sel(i_rt_execute, i_writereg_memory, i_regwrite_memory,
                                  i_writereg_writeback, i_regwrite_writeback);
    o_forward_decode[0] = i_regwrite_memory && reg_match(i_writereg_memory, i_rs_decode);
    o_forward_decode[1] = i_regwrite_memory && reg_match(i_writereg_memory, i_rt_decode);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch stalls, flushes, forwarding,
// data-memory wait sequencing with timeout watchdog and a stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_rs_decode,
  input  logic [4:0]       i_rt_decode,
  input  logic [4:0]       i_rs_execute,
  input  logic [4:0]       i_rt_execute,
  input  logic [4:0]       i_writereg_execute,
  input  logic [4:0]       i_writereg_memory,
  input  logic [4:0]       i_writereg_writeback,
  input  logic             i_regwrite_execute,
  input  logic             i_regwrite_memory,
  input  logic             i_regwrite_writeback,
  input  logic             i_memtoreg_execute,
  input  logic             i_memtoreg_memory,
  input  logic             i_branch_decode,
  input  logic             i_jump_decode,
  input  logic             i_pcsrc_decode,
  input  logic             i_memaccess_memory,
  input  logic             i_dmem_ready,
  output logic             o_stall_front,
  output logic             o_stall_back,
  output logic             o_flush_decode,
  output logic             o_flush_execute,
  output logic             o_flush_writeback,
  output logic [1:0]       o_forward_decode,
  output logic [1:0]       o_forward_a_execute,
  output logic [1:0]       o_forward_b_execute,
  output logic             o_mem_error,
  output logic [CNT_W-1:0] o_stall_cycles
);

  localparam logic [15:0] LP_WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_wait_cnt, w_wait_cnt_nxt;
  logic        r_mem_error;
  logic [CNT_W-1:0] r_stall_cycles;
  logic        w_err_set;
  logic        w_lwstall, w_brstall, w_memstall;

  hazard_ctrl_forward_unit u_forward_unit (
    .i_rs_decode          (i_rs_decode),
    .i_rt_decode          (i_rt_decode),
    .i_rs_execute         (i_rs_execute),
    .i_rt_execute         (i_rt_execute),
    .i_writereg_memory    (i_writereg_memory),
    .i_writereg_writeback (i_writereg_writeback),
    .i_regwrite_memory    (i_regwrite_memory),
    .i_regwrite_writeback (i_regwrite_writeback),
    .o_forward_decode     (o_forward_decode),
    .o_forward_a_execute  (o_forward_a_execute),
    .o_forward_b_execute  (o_forward_b_execute)
  );

  assign w_lwstall  = i_memtoreg_execute &&
                      (reg_match(i_rt_execute, i_rs_decode) || reg_match(i_rt_execute, i_rt_decode));
  assign w_brstall  = i_branch_decode &&
                      ((i_regwrite_execute &&
                        (reg_match(i_writereg_execute, i_rs_decode) ||
                         reg_match(i_writereg_execute, i_rt_decode))) ||
                       (i_memtoreg_memory &&
                        (reg_match(i_writereg_memory, i_rs_decode) ||
                         reg_match(i_writereg_memory, i_rt_decode))));
  assign w_memstall = i_memaccess_memory && !i_dmem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_RUN;
      r_wait_cnt     <= '0;
      r_mem_error    <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_err_set) r_mem_error <= 1'b1;
      if (o_stall_front && (r_stall_cycles != {CNT_W{1'b1}}))
        r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_err_set         = 1'b0;
    o_stall_front     = 1'b0;
    o_stall_back      = 1'b0;
    o_flush_decode    = 1'b0;
    o_flush_execute   = 1'b0;
    o_flush_writeback = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (w_memstall) begin
          w_state_nxt    = ST_MEM_WAIT;
          w_wait_cnt_nxt = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (i_dmem_ready) begin
          w_state_nxt = ST_RUN;
        end else if (r_wait_cnt == LP_WAIT_LAST) begin
          w_state_nxt = ST_HALT;
          w_err_set   = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 16'd1;
        end
      end
      ST_HALT: ;
      default: w_state_nxt = ST_RUN;
    endcase

    // A load-use stall outranks a jump; the jump is re-evaluated once the stall clears.
    if (r_state == ST_HALT || w_memstall) begin
      o_stall_front     = 1'b1;
      o_stall_back      = 1'b1;
      o_flush_writeback = 1'b1;
    end else if (w_lwstall || w_brstall) begin
      o_stall_front   = 1'b1;
      o_flush_execute = 1'b1;
    end else begin
      o_flush_decode = i_jump_decode || i_pcsrc_decode;
    end
  end

  assign o_mem_error    = r_mem_error;
  assign o_stall_cycles = r_stall_cycles;

endmodule
